// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder (one word per line).
// Define DCACHE_STATS_EN to build the load hit/miss counters; otherwise both read as zero.
module dcache_responder #(
    parameter int LINES_LOG2 = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cache_rd,
    input  logic        cache_wr,
    input  logic [31:0] cache_addr,
    input  logic [31:0] cache_wr_data,
    input  logic [3:0]  cache_wr_be,
    output logic [31:0] cache_data,
    output logic        cache_waitrequest,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_be,
    input  logic [31:0] mem_data,
    input  logic        mem_waitrequest,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES = 1 << LINES_LOG2;
    localparam int TAG_W = 30 - LINES_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_mem [LINES];
    logic [31:0]             data_mem [LINES];

    logic [LINES_LOG2-1:0]   idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    hit;
    logic                    fill_accept;
    logic                    write_accept;
    logic [31:0]             line_word;
    logic [31:0]             merged_word;
    logic                    unused_addr_bits;

    assign idx              = cache_addr[LINES_LOG2+1:2];
    assign req_tag          = cache_addr[31:LINES_LOG2+2];
    assign line_word        = data_mem[idx];
    assign hit              = valid_q[idx] && (tag_mem[idx] == req_tag);
    assign fill_accept      = (state_q == ST_FILL) && !mem_waitrequest;
    assign write_accept     = (state_q == ST_WRITE) && !mem_waitrequest;
    assign mem_addr         = {cache_addr[31:2], 2'b00};
    assign unused_addr_bits = ^cache_addr[1:0];

    // Store merge: only enabled byte lanes replace the cached word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[gi*8 +: 8] = cache_wr_be[gi] ? cache_wr_data[gi*8 +: 8]
                                                             : line_word[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cache_wr) begin
                    state_d = ST_WRITE;
                end else if (cache_rd && !hit) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!mem_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!mem_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so an abandoned memory request drops at once.
    always_comb begin
        cache_waitrequest = 1'b0;
        cache_data        = 32'h0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_wr_data       = 32'h0;
        mem_wr_be         = 4'h0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (cache_wr) begin
                        cache_waitrequest = 1'b1;
                    end else if (cache_rd) begin
                        if (hit) begin
                            cache_data = line_word;
                        end else begin
                            cache_waitrequest = 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    mem_rd            = 1'b1;
                    cache_waitrequest = 1'b1;
                end
                ST_WRITE: begin
                    mem_wr            = 1'b1;
                    mem_wr_data       = cache_wr_data;
                    mem_wr_be         = cache_wr_be;
                    cache_waitrequest = mem_waitrequest;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_accept) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Write misses leave the line untouched (no allocate).
    always_ff @(posedge clock) begin
        if (fill_accept) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= mem_data;
        end else if (write_accept && hit) begin
            data_mem[idx] <= merged_word;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        fill_done_q;
    logic        rd_ack;

    assign rd_ack = (state_q == ST_IDLE) && cache_rd && !cache_wr && hit;

    // The hit that completes a fill belongs to the miss, not to the hit count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
            fill_done_q  <= 1'b0;
        end else begin
            fill_done_q <= fill_accept;
            if (rd_ack && !fill_done_q) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_FILL)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: miss/fill, hits, write-through merge, eviction, reset abandonment.
module tb_dcache_responder;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        cache_rd;
    logic        cache_wr;
    logic [31:0] cache_addr;
    logic [31:0] cache_wr_data;
    logic [3:0]  cache_wr_be;
    logic [31:0] cache_data;
    logic        cache_waitrequest;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic [31:0] mem_data;
    logic        mem_waitrequest;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    dcache_responder #(.LINES_LOG2(6)) dut (
        .clock             (clock),
        .reset             (reset),
        .cache_rd          (cache_rd),
        .cache_wr          (cache_wr),
        .cache_addr        (cache_addr),
        .cache_wr_data     (cache_wr_data),
        .cache_wr_be       (cache_wr_be),
        .cache_data        (cache_data),
        .cache_waitrequest (cache_waitrequest),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_be         (mem_wr_be),
        .mem_data          (mem_data),
        .mem_waitrequest   (mem_waitrequest),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 4 units later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        cache_rd        = 1'b0;
        cache_wr        = 1'b0;
        cache_addr      = 32'h0;
        cache_wr_data   = 32'h0;
        cache_wr_be     = 4'h0;
        mem_data        = 32'h0;
        mem_waitrequest = 1'b1;
        #3;
        chk("rst_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_data", cache_data, 32'h0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // Load miss at 0x100, memory stalls three cycles.
        cyc();
        cache_rd = 1'b1;
        cache_addr = 32'h100;
        #4;
        chk("miss_idle_wait", {31'b0, cache_waitrequest}, 32'd1);
        chk("miss_idle_mem_rd", {31'b0, mem_rd}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) begin
                mem_waitrequest = 1'b0;
                mem_data = 32'hDEADBEEF;
            end
            #4;
            chk("fill_mem_rd", {31'b0, mem_rd}, 32'd1);
            chk("fill_addr", mem_addr, 32'h100);
            chk("fill_wait", {31'b0, cache_waitrequest}, 32'd1);
        end
        cyc();
        mem_waitrequest = 1'b1;
        mem_data = 32'h0;
        #4;
        chk("fill_ack_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("fill_ack_data", cache_data, 32'hDEADBEEF);
        chk("fill_ack_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("fill_misses", miss_count, STATS ? 32'd1 : 32'd0);
        chk("fill_hits", hit_count, 32'd0);
        $display("txn rd 0x100 miss data=%h", cache_data);

        // Immediate second read hits in the same cycle.
        cyc();
        #4;
        chk("hit_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("hit_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("hit_data", cache_data, 32'hDEADBEEF);
        $display("txn rd 0x100 hit data=%h", cache_data);
        cyc();
        cache_rd = 1'b0;
        #4;
        chk("hit_count1", hit_count, STATS ? 32'd1 : 32'd0);
        chk("idle_data_zero", cache_data, 32'h0);

        // Store hit with partial byte enables, memory stalls two cycles.
        cyc();
        cache_wr = 1'b1;
        cache_addr = 32'h100;
        cache_wr_data = 32'h11223344;
        cache_wr_be = 4'b0011;
        #4;
        chk("wr_idle_wait", {31'b0, cache_waitrequest}, 32'd1);
        chk("wr_idle_mem_wr", {31'b0, mem_wr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) mem_waitrequest = 1'b0;
            #4;
            chk("wr_mem_wr", {31'b0, mem_wr}, 32'd1);
            chk("wr_mem_rd", {31'b0, mem_rd}, 32'd0);
            chk("wr_addr", mem_addr, 32'h100);
            chk("wr_data", mem_wr_data, 32'h11223344);
            chk("wr_be", {28'b0, mem_wr_be}, 32'h3);
            chk("wr_wait", {31'b0, cache_waitrequest}, (i == 2) ? 32'd0 : 32'd1);
        end
        $display("txn wr 0x100 data=11223344 be=0011");
        cyc();
        cache_wr = 1'b0;
        mem_waitrequest = 1'b1;
        cache_rd = 1'b1;
        #4;
        chk("merge_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("merge_data", cache_data, 32'hDEAD3344);
        $display("txn rd 0x100 hit data=%h", cache_data);

        // Store miss to 0x200 (same index) goes to memory without allocating.
        cyc();
        cache_rd = 1'b0;
        cache_wr = 1'b1;
        cache_addr = 32'h200;
        cache_wr_data = 32'h55667788;
        cache_wr_be = 4'hF;
        #4;
        chk("wrmiss_idle_wait", {31'b0, cache_waitrequest}, 32'd1);
        cyc();
        mem_waitrequest = 1'b0;
        #4;
        chk("wrmiss_mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("wrmiss_addr", mem_addr, 32'h200);
        chk("wrmiss_data", mem_wr_data, 32'h55667788);
        chk("wrmiss_wait", {31'b0, cache_waitrequest}, 32'd0);
        $display("txn wr 0x200 data=55667788 be=1111");
        cyc();
        cache_wr = 1'b0;
        mem_waitrequest = 1'b1;
        cache_rd = 1'b1;
        cache_addr = 32'h100;
        #4;
        chk("noalloc_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("noalloc_data", cache_data, 32'hDEAD3344);
        $display("txn rd 0x100 hit data=%h", cache_data);

        // Store with no byte enables still reaches memory and changes nothing.
        cyc();
        cache_rd = 1'b0;
        cache_wr = 1'b1;
        cache_wr_data = 32'hFFFFFFFF;
        cache_wr_be = 4'b0000;
        #4;
        chk("be0_idle_wait", {31'b0, cache_waitrequest}, 32'd1);
        cyc();
        mem_waitrequest = 1'b0;
        #4;
        chk("be0_mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("be0_be", {28'b0, mem_wr_be}, 32'h0);
        chk("be0_wait", {31'b0, cache_waitrequest}, 32'd0);
        $display("txn wr 0x100 data=ffffffff be=0000");
        cyc();
        cache_wr = 1'b0;
        mem_waitrequest = 1'b1;
        cache_rd = 1'b1;
        #4;
        chk("be0_rd_data", cache_data, 32'hDEAD3344);
        $display("txn rd 0x100 hit data=%h", cache_data);

        // Load 0x200 evicts 0x100.
        cyc();
        cache_addr = 32'h200;
        #4;
        chk("evict_idle_wait", {31'b0, cache_waitrequest}, 32'd1);
        chk("hit_count4", hit_count, STATS ? 32'd4 : 32'd0);
        cyc();
        mem_waitrequest = 1'b0;
        mem_data = 32'hCAFEF00D;
        #4;
        chk("evict_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("evict_addr", mem_addr, 32'h200);
        cyc();
        mem_waitrequest = 1'b1;
        mem_data = 32'h0;
        #4;
        chk("evict_ack_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("evict_ack_data", cache_data, 32'hCAFEF00D);
        $display("txn rd 0x200 miss data=%h", cache_data);
        cyc();
        cache_addr = 32'h100;
        #4;
        chk("evicted_wait", {31'b0, cache_waitrequest}, 32'd1);
        chk("misses2", miss_count, STATS ? 32'd2 : 32'd0);
        chk("hits_after_fill", hit_count, STATS ? 32'd4 : 32'd0);
        cyc();
        #4;
        chk("refill_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("refill_addr", mem_addr, 32'h100);

        // Reset in the middle of the fill abandons it immediately.
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("midrst_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("midrst_data", cache_data, 32'h0);
        chk("midrst_misses", miss_count, 32'd0);
        chk("midrst_hits", hit_count, 32'd0);
        $display("txn rd 0x100 abandoned by reset");
        cyc();
        cyc();
        reset = 1'b0;
        #4;
        chk("postrst_wait", {31'b0, cache_waitrequest}, 32'd1);
        chk("postrst_mem_rd", {31'b0, mem_rd}, 32'd0);
        cyc();
        #4;
        chk("postrst_fill_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("postrst_fill_addr", mem_addr, 32'h100);
        cyc();
        mem_waitrequest = 1'b0;
        mem_data = 32'h12345678;
        #4;
        chk("postrst_fill_hold", {31'b0, mem_rd}, 32'd1);
        cyc();
        mem_waitrequest = 1'b1;
        mem_data = 32'h0;
        #4;
        chk("postrst_ack_wait", {31'b0, cache_waitrequest}, 32'd0);
        chk("postrst_ack_data", cache_data, 32'h12345678);
        $display("txn rd 0x100 miss data=%h", cache_data);
        cyc();
        cache_rd = 1'b0;
        #4;
        chk("final_misses", miss_count, STATS ? 32'd1 : 32'd0);
        chk("final_hits", hit_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Cache-side responder for the load/store unit's data cache port: cache_rd/cache_wr/cache_addr/cache_wr_data/cache_wr_be in, cache_data/cache_waitrequest out.
- Direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
- Misses and all writes go to a backing-memory port that uses the same waitrequest protocol.
- Sits between the LS pipeline's MEM stage and the memory/bus arbiter.

Parameters:
- LINES_LOG2, 6, log2 of the number of lines. Index = addr[LINES_LOG2+1:2]; tag = addr[31:LINES_LOG2+2].

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cache_rd  in  1  load request, held until accepted
- cache_wr  in  1  store request, held until accepted
- cache_addr  in  32  byte address; bits [1:0] ignored
- cache_wr_data  in  32  store data
- cache_wr_be  in  4  store byte enables, bit n = byte n
- cache_data  out  32  load data, valid when cache_rd=1 and cache_waitrequest=0
- cache_waitrequest  out  1  high = request not accepted this cycle
- mem_rd  out  1  fill read to memory
- mem_wr  out  1  write-through to memory
- mem_addr  out  32  word-aligned memory address
- mem_wr_data  out  32  write data
- mem_wr_be  out  4  write byte enables
- mem_data  in  32  read data, valid when mem_rd=1 and mem_waitrequest=0
- mem_waitrequest  in  1  high = memory has not accepted the request
- hit_count  out  32  load hits (optional feature)
- miss_count  out  32  load misses (optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - All valid bits cleared, FSM to IDLE.
  - mem_rd=0, mem_wr=0, cache_waitrequest=0, cache_data=0, counters=0.
  - Tag/data arrays are not reset.
- hit = valid[idx] and tag[idx]==cache_addr tag.
- Protocol: a request completes in the cycle its rd/wr is high and waitrequest is low. The initiator holds addr/data/be stable while waitrequest is high.
- FSM IDLE:
  - No request: cache_waitrequest=0.
  - cache_rd & hit: cache_waitrequest=0, cache_data=data[idx] combinationally. Zero-cycle hit, no memory traffic.
  - cache_rd & ~hit: cache_waitrequest=1, go FILL.
  - cache_wr: cache_waitrequest=1, go WRITE.
  - cache_rd & cache_wr together: illegal; write wins.
  - cache_data=0 whenever no read is being acknowledged.
- FSM FILL:
  - mem_rd=1, mem_addr={cache_addr[31:2],2'b00}, cache_waitrequest=1.
  - On mem_waitrequest=0: write mem_data and tag into line idx, set valid, go IDLE.
  - The held read then hits on the next cycle. Miss latency = memory latency + 1 cycle.
- FSM WRITE:
  - mem_wr=1, mem_addr word-aligned, mem_wr_data/mem_wr_be = cache inputs.
  - cache_waitrequest = mem_waitrequest (combinational pass-through).
  - On acceptance: if hit, merge enabled byte lanes into data[idx]. If miss, no allocate and the line is unchanged. Go IDLE.
  - be=4'b0000 is still forwarded to memory and completes normally.
- Conflict: a fill to an index replaces the previous tag (eviction). No dirty state exists.
- Reset mid-FILL/WRITE: the memory request drops immediately and the transaction is abandoned. The memory side must tolerate abandonment.
- mem_rd and mem_wr are never both high.

Optional Feature:
- DCACHE_STATS_EN defined:
  - hit_count increments by 1 on each acknowledged read that hit in IDLE without a preceding fill.
  - miss_count increments by 1 on each entry into FILL.
  - Both wrap at 2^32 and are cleared by reset.
- Not defined: hit_count and miss_count are tied to 32'h0 and no counter registers exist.

Test Plan:
- Reset, rd 0x100; memory holds waitrequest 3 cycles then returns 0xDEADBEEF -> mem_rd=1 with addr 0x100 for 4 cycles, cache_waitrequest high for 5 cycles, then low with cache_data=0xDEADBEEF; miss_count=1.
- Immediate second rd 0x100 -> cache_waitrequest=0 in the same cycle, mem_rd stays 0, cache_data=0xDEADBEEF; hit_count=1.
- wr 0x100 data 0x11223344 be 4'b0011, mem_waitrequest high 2 cycles -> mem_wr=1 for 3 cycles with data/be passed through, cache_waitrequest low in cycle 3. Then rd 0x100 hits with 0xDEAD3344.
- wr 0x200 (same index, tag differs) -> memory write issued, no allocate. rd 0x100 still hits 0xDEAD3344.
- rd 0x200 (mem returns 0xCAFEF00D) -> evicts 0x100. Next rd 0x100 misses and mem_rd is asserted.
- Assert reset during FILL -> mem_rd=0 and cache_waitrequest=0 immediately. After release, rd 0x100 misses even though it was previously filled.
